// File: rtl/master_axi_test_pkg.sv
// Shared types for master_axi_test: start-up state enum, FIFO entry layout
// (default 32-bit width) and pointer width helper.
package master_axi_test_pkg;

  typedef enum logic {
    INIT_COUNTER = 1'b0,
    SEND_STREAM  = 1'b1
  } master_state_t;

  localparam int AXIS_DATA_W = 32;

  // Field order matches the {tdata, tstrb, tlast} packing used in the FIFO.
  typedef struct packed {
    logic [AXIS_DATA_W-1:0]   tdata;
    logic [AXIS_DATA_W/8-1:0] tstrb;
    logic                     tlast;
  } axis_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/count.
// Write is dropped when full, read is ignored when empty.
module axis_sync_fifo
  import master_axi_test_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 37,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [PW-1:0] o_count
);

  localparam int AW = PW - 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_count;
  logic          w_wr, w_rd;

  // The extra pointer MSB distinguishes full from empty when indices match.
  assign o_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/master_axi_test.sv
// AXI4-Stream buffering bridge: s00 -> FIFO -> m00 after a start-up delay.
// Optional packet store-and-forward via MASTER_AXI_TEST_STORE_FORWARD_EN.
module master_axi_test
  import master_axi_test_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_START_COUNT = 32,
  parameter int C_FIFO_DEPTH           = 16
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_aresetn,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready
);

  localparam int PW = ptr_w(C_FIFO_DEPTH);
  localparam int EW = C_S00_AXIS_TDATA_WIDTH + C_S00_AXIS_TDATA_WIDTH/8 + 1;

  master_state_t r_state;
  logic [31:0]   r_start_cnt;
  logic [PW-1:0] w_count;
  logic [EW-1:0] w_head;
  logic          w_full, w_empty, w_wr_fire, w_rd_fire, w_send_ok;
  logic          w_unused;

  // m00 clock/reset are tied to s00 externally.
  assign w_unused = &{1'b0, m00_axis_aclk, m00_axis_aresetn, w_full};

  assign s00_axis_tready = s00_axis_aresetn && (w_count != PW'(C_FIFO_DEPTH));
  assign w_wr_fire       = s00_axis_tvalid && s00_axis_tready;
  assign m00_axis_tvalid = (r_state == SEND_STREAM) && (w_count != '0) && w_send_ok;
  assign w_rd_fire       = m00_axis_tvalid && m00_axis_tready;
  assign {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast} = m00_axis_tvalid ? w_head : '0;

  axis_sync_fifo #(
    .DEPTH (C_FIFO_DEPTH),
    .W     (EW),
    .PW    (PW)
  ) u_fifo (
    .clk       (s00_axis_aclk),
    .rst_n     (s00_axis_aresetn),
    .i_wr_en   (w_wr_fire),
    .i_wr_data ({s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast}),
    .i_rd_en   (w_rd_fire),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state     <= INIT_COUNTER;
      r_start_cnt <= '0;
    end else begin
      case (r_state)
        INIT_COUNTER: begin
          if (r_start_cnt == 32'(C_M00_AXIS_START_COUNT - 1)) r_state <= SEND_STREAM;
          else r_start_cnt <= r_start_cnt + 32'd1;
        end
        default: r_state <= SEND_STREAM;
      endcase
    end
  end

`ifdef MASTER_AXI_TEST_STORE_FORWARD_EN
  logic [PW-1:0] r_pkt_cnt;
  logic          w_pkt_in, w_pkt_out;

  assign w_pkt_in  = w_wr_fire && s00_axis_tlast;
  assign w_pkt_out = w_rd_fire && w_head[0];
  // A full FIFO with no tlast would never drain; let it cut through.
  assign w_send_ok = (r_pkt_cnt != '0) || w_full;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) r_pkt_cnt <= '0;
    else if (w_pkt_in && !w_pkt_out) r_pkt_cnt <= r_pkt_cnt + 1'b1;
    else if (!w_pkt_in && w_pkt_out) r_pkt_cnt <= r_pkt_cnt - 1'b1;
  end
`else
  assign w_send_ok = 1'b1;
`endif

endmodule

// File: tb/tb_master_axi_test.sv
// Randomized directed bench for master_axi_test against a queue-based
// reference model (start delay, FIFO ordering, optional store-forward).
module tb_master_axi_test;

  localparam int DEPTH = 16;
  localparam int START = 32;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = '0;
  logic        s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast, m_tvalid;
  logic        m_tready = 1'b0;

  ent_t q[$];
  int   cyc = 0;
  int   vec = 0;
  int   err = 0;
  int   pops = 0;

  always #5 clk = ~clk;

  master_axi_test dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tready  (s_tready),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tstrb   (m_tstrb),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tready  (m_tready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_valid();
    int pk = 0;
    if (!rst_n || cyc < START || q.size() == 0) return 1'b0;
`ifdef MASTER_AXI_TEST_STORE_FORWARD_EN
    foreach (q[i]) if (q[i].l) pk++;
    return (pk != 0) || (q.size() == DEPTH);
`else
    return 1'b1 | (pk != 0);
`endif
  endfunction

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic step(input bit v, input logic [31:0] d, input bit l,
                      input bit mr, output bit acc);
    bit          er, ev;
    logic [3:0]  s;
    ent_t        e;
    s = 4'($urandom);
    s_tvalid = v; s_tdata = d; s_tstrb = s; s_tlast = l; m_tready = mr;
    @(negedge clk);
    er = rst_n && (q.size() < DEPTH);
    ev = model_valid();
    chk("s_tready", 64'(s_tready), 64'(er));
    chk("m_tvalid", 64'(m_tvalid), 64'(ev));
    if (ev) chk("m_payload", 64'({m_tdata, m_tstrb, m_tlast}), 64'({q[0].d, q[0].s, q[0].l}));
    else    chk("m_idle_zero", 64'({m_tdata, m_tstrb, m_tlast}), 64'(0));
    @(posedge clk);
    acc = v && er;
    if (!rst_n) begin
      q.delete();
      cyc = 0;
    end else begin
      if (ev && mr) begin void'(q.pop_front()); pops++; end
      if (acc) begin e.d = d; e.s = s; e.l = l; q.push_back(e); end
      if (cyc < START) cyc++;
    end
    #1;
  endtask

  initial begin
    bit acc;
    int idx;

    // reset with stimulus active
    for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD0000 + i, 1'b1, 1'b1, acc);
    rst_n = 1'b1;

    // start-up delay while pushing 0..20
    idx = 0;
    for (int n = 0; n < 60; n++) begin
      step(idx < 21, 32'(idx), idx == 20, 1'b1, acc);
      if (acc) idx++;
    end
    chk("startup_all_accepted", 64'(idx), 64'd21);
    for (int n = 0; n < 40 && q.size() != 0; n++) step(1'b0, '0, 1'b0, 1'b1, acc);

    // full stream with random gaps on both sides
    idx = 0; pops = 0;
    for (int n = 0; n < 600 && (idx < 32 || q.size() != 0); n++) begin
      step((idx < 32) && ($urandom_range(0, 3) != 0), 32'(idx), (idx % 4) == 3,
           $urandom_range(0, 3) != 0, acc);
      if (acc) idx++;
    end
    chk("stream_pushed", 64'(idx), 64'd32);
    chk("stream_popped", 64'(pops), 64'd32);

    // backpressure with word 7 at head
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i), i == 9, 1'b0, acc);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, acc);
      chk("bp_hold_data", 64'(m_tdata), 64'd7);
      chk("bp_hold_valid", 64'(m_tvalid), 64'd1);
    end
    for (int n = 0; n < 20 && q.size() != 0; n++) step(1'b0, '0, 1'b0, 1'b1, acc);

    // reset mid-stream after 10 words emitted
    idx = 0; pops = 0;
    for (int n = 0; n < 200 && pops < 10; n++) begin
      step(idx < 20, 32'(200 + idx), (idx % 5) == 4, 1'b1, acc);
      if (acc) idx++;
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b1, 32'hBAD, 1'b1, 1'b1, acc);
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) step(1'b0, '0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b1, 32'(300 + i), i == 2, 1'b1, acc);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, acc);

    // packet gating: 3 words, then tlast word, then oversized packet
    for (int i = 0; i < 3; i++) step(1'b1, 32'(400 + i), 1'b0, 1'b1, acc);
    step(1'b1, 32'd403, 1'b1, 1'b1, acc);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 16; i++) step(1'b1, 32'(500 + i), 1'b0, 1'b1, acc);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1, acc);
    idx = 0;
    for (int n = 0; n < 20 && idx == 0; n++) begin
      step(1'b1, 32'd600, 1'b1, 1'b1, acc);
      if (acc) idx++;
    end
    for (int n = 0; n < 40 && q.size() != 0; n++) step(1'b0, '0, 1'b0, 1'b1, acc);
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
